// File: rtl/spu_pkg.sv
// Shared SPU definitions: packed stage-result layout, unit codes and the
// register-address and data widths used by the even-pipe operand fetch.
package spu_pkg;

  localparam int PACKED_W   = 143;
  localparam int REG_ADDR_W = 7;
  localparam int DATA_W     = 128;

  localparam int UNIT_LSB   = 0;
  localparam int UNIT_W     = 3;
  localparam int RESULT_LSB = 3;
  localparam int RESULT_W   = 128;
  localparam int DST_LSB    = 131;
  localparam int DST_W      = 7;
  localparam int LAT_LSB    = 138;
  localparam int LAT_W      = 4;
  localparam int REGWR_LSB  = 142;
  localparam int REGWR_W    = 1;

  typedef enum logic [UNIT_W-1:0] {
    UNIT_NONE = 3'd0,
    UNIT_FX1  = 3'd1,
    UNIT_FX2  = 3'd2,
    UNIT_SP   = 3'd3,
    UNIT_BYTE = 3'd4
  } unit_e;

  // Member order mirrors the tap bit layout, MSB first, so a tap casts directly.
  typedef struct packed {
    logic                  regwr;
    logic [LAT_W-1:0]      lat;
    logic [DST_W-1:0]      dst;
    logic [RESULT_W-1:0]   result;
    logic [UNIT_W-1:0]     unit;
  } packed_result_t;

  function automatic packed_result_t unpackTap(input logic [PACKED_W-1:0] raw);
    return packed_result_t'(raw);
  endfunction

endpackage

// File: rtl/even_operand_fetch_if.sv
// Issue, tap, write-back and registered-operand signals between the issue
// stage and the even-pipe operand fetch.
interface even_operand_fetch_if
  import spu_pkg::*;
#(
  parameter int NUM_TAPS    = 7,
  parameter int STALL_CNT_W = 16
);

  logic                   in_valid;
  logic [31:0]            in_instr;
  logic [6:0]             in_instr_id;
  logic [2:0]             in_unit_id;
  logic [REG_ADDR_W-1:0]  in_reg_dst;
  logic [3:0]             in_latency;
  logic                   in_reg_wr;
  logic [2:0]             in_uses;
  logic [REG_ADDR_W-1:0]  ra_addr;
  logic [REG_ADDR_W-1:0]  rb_addr;
  logic [REG_ADDR_W-1:0]  rc_addr;
  logic [DATA_W-1:0]      rf_ra_data;
  logic [DATA_W-1:0]      rf_rb_data;
  logic [DATA_W-1:0]      rf_rc_data;
  logic [NUM_TAPS:1][PACKED_W-1:0] tap;
  logic [REG_ADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   wb_en;

  logic                   stall;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_ra;
  logic [DATA_W-1:0]      out_rb;
  logic [DATA_W-1:0]      out_rc;
  logic [31:0]            out_instr;
  logic [6:0]             out_instr_id;
  logic [2:0]             out_unit_id;
  logic [REG_ADDR_W-1:0]  out_reg_dst;
  logic [3:0]             out_latency;
  logic                   out_reg_wr;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instr, in_instr_id, in_unit_id, in_reg_dst, in_latency,
           in_reg_wr, in_uses, ra_addr, rb_addr, rc_addr,
           rf_ra_data, rf_rb_data, rf_rc_data, tap, wb_addr, wb_data, wb_en,
    input  stall, out_valid, out_ra, out_rb, out_rc, out_instr, out_instr_id,
           out_unit_id, out_reg_dst, out_latency, out_reg_wr, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_instr_id, in_unit_id, in_reg_dst, in_latency,
           in_reg_wr, in_uses, ra_addr, rb_addr, rc_addr,
           rf_ra_data, rf_rb_data, rf_rc_data, tap, wb_addr, wb_data, wb_en,
    output stall, out_valid, out_ra, out_rb, out_rc, out_instr, out_instr_id,
           out_unit_id, out_reg_dst, out_latency, out_reg_wr, stall_cnt
  );

endinterface

// File: rtl/even_operand_fetch_fwd_select.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of one
// source register and flags a hazard when that producer is not ready yet.
module fwd_select
  import spu_pkg::*;
#(
  parameter int NUM_TAPS = 7
) (
  input  logic [REG_ADDR_W-1:0]         addr_i,
  input  logic [DATA_W-1:0]             rf_data_i,
  input  logic [NUM_TAPS:1][PACKED_W-1:0] taps_i,
  input  logic                          wb_en_i,
  input  logic [REG_ADDR_W-1:0]         wb_addr_i,
  input  logic [DATA_W-1:0]             wb_data_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          hazard_o
);

  packed_result_t curTap;

  // Scan oldest to youngest so each younger match overrides the older one;
  // write-back is the oldest source and is always ready.
  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    curTap   = '0;
    if (wb_en_i && (wb_addr_i == addr_i)) begin
      data_o = wb_data_i;
    end
    for (int k = NUM_TAPS; k >= 1; k--) begin
      curTap = unpackTap(taps_i[k]);
      if (curTap.regwr && (curTap.dst == addr_i)) begin
        if (int'(curTap.lat) <= k) begin
          data_o   = curTap.result;
          hazard_o = 1'b0;
        end else begin
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/even_operand_fetch.sv
// Even-pipe register fetch: forwards ra/rb/rc from in-flight producers or the
// register file, stalls issue on unready producers, and registers the operands.
module even_operand_fetch
  import spu_pkg::*;
#(
  parameter int NUM_TAPS    = 7,
  parameter int STALL_CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  even_operand_fetch_if.slave bus
);

  logic [DATA_W-1:0] raSel, rbSel, rcSel;
  logic [2:0]        hazard;
  logic              stall;

  fwd_select #(.NUM_TAPS(NUM_TAPS)) u_fwd_ra (
    .addr_i(bus.ra_addr), .rf_data_i(bus.rf_ra_data), .taps_i(bus.tap),
    .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
    .data_o(raSel), .hazard_o(hazard[0])
  );

  fwd_select #(.NUM_TAPS(NUM_TAPS)) u_fwd_rb (
    .addr_i(bus.rb_addr), .rf_data_i(bus.rf_rb_data), .taps_i(bus.tap),
    .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
    .data_o(rbSel), .hazard_o(hazard[1])
  );

  fwd_select #(.NUM_TAPS(NUM_TAPS)) u_fwd_rc (
    .addr_i(bus.rc_addr), .rf_data_i(bus.rf_rc_data), .taps_i(bus.tap),
    .wb_en_i(bus.wb_en), .wb_addr_i(bus.wb_addr), .wb_data_i(bus.wb_data),
    .data_o(rcSel), .hazard_o(hazard[2])
  );

  assign stall = bus.in_valid & (|(hazard & bus.in_uses));

  logic [DATA_W-1:0]      ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [31:0]            instr_q, instr_d;
  logic [6:0]             instrId_q, instrId_d;
  logic [2:0]             unitId_q, unitId_d;
  logic [REG_ADDR_W-1:0]  regDst_q, regDst_d;
  logic [3:0]             latency_q, latency_d;
  logic                   regWr_q, regWr_d;
  logic                   valid_q, valid_d;
  logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

  // Unused operands bypass forwarding and present the raw register-file data.
  always_comb begin
    ra_d       = ra_q;
    rb_d       = rb_q;
    rc_d       = rc_q;
    instr_d    = instr_q;
    instrId_d  = instrId_q;
    unitId_d   = unitId_q;
    regDst_d   = regDst_q;
    latency_d  = latency_q;
    regWr_d    = regWr_q;
    valid_d    = 1'b0;
    stallCnt_d = stallCnt_q;
    if (stall) begin
      if (stallCnt_q != '1) begin
        stallCnt_d = stallCnt_q + 1'b1;
      end
    end else begin
      ra_d      = bus.in_uses[0] ? raSel : bus.rf_ra_data;
      rb_d      = bus.in_uses[1] ? rbSel : bus.rf_rb_data;
      rc_d      = bus.in_uses[2] ? rcSel : bus.rf_rc_data;
      instr_d   = bus.in_instr;
      instrId_d = bus.in_instr_id;
      unitId_d  = bus.in_unit_id;
      regDst_d  = bus.in_reg_dst;
      latency_d = bus.in_latency;
      regWr_d   = bus.in_reg_wr;
      valid_d   = bus.in_valid;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ra_q       <= '0;
      rb_q       <= '0;
      rc_q       <= '0;
      instr_q    <= '0;
      instrId_q  <= '0;
      unitId_q   <= '0;
      regDst_q   <= '0;
      latency_q  <= '0;
      regWr_q    <= 1'b0;
      valid_q    <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      ra_q       <= ra_d;
      rb_q       <= rb_d;
      rc_q       <= rc_d;
      instr_q    <= instr_d;
      instrId_q  <= instrId_d;
      unitId_q   <= unitId_d;
      regDst_q   <= regDst_d;
      latency_q  <= latency_d;
      regWr_q    <= regWr_d;
      valid_q    <= valid_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.out_valid    = valid_q;
  assign bus.out_ra       = ra_q;
  assign bus.out_rb       = rb_q;
  assign bus.out_rc       = rc_q;
  assign bus.out_instr    = instr_q;
  assign bus.out_instr_id = instrId_q;
  assign bus.out_unit_id  = unitId_q;
  assign bus.out_reg_dst  = regDst_q;
  assign bus.out_latency  = latency_q;
  assign bus.out_reg_wr   = regWr_q;
  assign bus.stall_cnt    = stallCnt_q;

endmodule

// File: tb/tb_even_operand_fetch.sv
// Directed bench for even_operand_fetch: forwarding priority, stalls,
// write-back bypass, unused operands and asynchronous reset mid-stall.
module tb_even_operand_fetch;
  import spu_pkg::*;

  logic clk;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;

  even_operand_fetch_if #(.NUM_TAPS(7), .STALL_CNT_W(16)) bus ();

  even_operand_fetch #(.NUM_TAPS(7), .STALL_CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [PACKED_W-1:0] mkTap(input logic [6:0] dst, input logic [3:0] lat,
                                                 input logic regWr, input logic [127:0] res);
    return {regWr, lat, dst, res, 3'd1};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearTaps();
    for (int k = 1; k <= 7; k++) bus.tap[k] = '0;
  endtask

  task automatic advanceTaps();
    for (int k = 7; k >= 2; k--) bus.tap[k] = bus.tap[k-1];
    bus.tap[1] = '0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [2:0] uses,
                               input logic [6:0] ra, input logic [6:0] rb, input logic [6:0] rc);
    bus.in_valid = valid;
    bus.in_uses  = uses;
    bus.ra_addr  = ra;
    bus.rb_addr  = rb;
    bus.rc_addr  = rc;
  endtask

  initial begin
    rst = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_instr_id = '0;
    bus.in_unit_id  = '0;
    bus.in_reg_dst  = '0;
    bus.in_latency  = '0;
    bus.in_reg_wr   = 1'b0;
    bus.in_uses     = '0;
    bus.ra_addr     = '0;
    bus.rb_addr     = '0;
    bus.rc_addr     = '0;
    bus.rf_ra_data  = '0;
    bus.rf_rb_data  = '0;
    bus.rf_rc_data  = '0;
    bus.wb_addr     = '0;
    bus.wb_data     = '0;
    bus.wb_en       = 1'b0;
    clearTaps();

    $display("[TB] reset state");
    #2;
    checkOutput("reset_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("reset_stall_cnt", 128'(bus.stall_cnt), 128'd0);
    checkOutput("reset_stall", 128'(bus.stall), 128'd0);
    checkOutput("reset_out_ra", bus.out_ra, 128'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] no producer match");
    bus.in_instr    = 32'hDEADBEEF;
    bus.in_instr_id = 7'h15;
    bus.in_unit_id  = 3'd3;
    bus.in_reg_dst  = 7'h20;
    bus.in_latency  = 4'd2;
    bus.in_reg_wr   = 1'b1;
    bus.rf_ra_data  = {16{8'hAA}};
    bus.rf_rb_data  = {16{8'hBB}};
    bus.rf_rc_data  = {16{8'hCC}};
    applyStimulus(1'b1, 3'b001, 7'd5, 7'd0, 7'd0);
    #1;
    checkOutput("nomatch_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("nomatch_out_ra", bus.out_ra, {16{8'hAA}});
    checkOutput("nomatch_out_rb_unused", bus.out_rb, {16{8'hBB}});
    checkOutput("nomatch_out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("pass_instr", 128'(bus.out_instr), 128'hDEADBEEF);
    checkOutput("pass_instr_id", 128'(bus.out_instr_id), 128'h15);
    checkOutput("pass_unit_id", 128'(bus.out_unit_id), 128'd3);
    checkOutput("pass_reg_dst", 128'(bus.out_reg_dst), 128'h20);
    checkOutput("pass_latency", 128'(bus.out_latency), 128'd2);
    checkOutput("pass_reg_wr", 128'(bus.out_reg_wr), 128'd1);

    $display("[TB] ready forward from tap 3");
    bus.tap[3] = mkTap(7'd5, 4'd2, 1'b1, {16{8'h11}});
    #1;
    checkOutput("fwd_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("fwd_out_ra", bus.out_ra, {16{8'h11}});

    $display("[TB] matching tap with RegWr=0 is ignored");
    clearTaps();
    bus.tap[1] = mkTap(7'd5, 4'd9, 1'b0, {16{8'hEE}});
    #1;
    checkOutput("noregwr_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("noregwr_out_ra", bus.out_ra, {16{8'hAA}});

    $display("[TB] not-ready producer stalls until tap 6");
    clearTaps();
    bus.tap[1] = mkTap(7'd5, 4'd6, 1'b1, {16{8'h66}});
    #1;
    checkOutput("stall_initial", 128'(bus.stall), 128'd1);
    for (int j = 1; j <= 5; j++) begin
      tick();
      checkOutput("stall_bubble_valid", 128'(bus.out_valid), 128'd0);
      advanceTaps();
      #1;
      checkOutput("stall_progress", 128'(bus.stall), (j < 5) ? 128'd1 : 128'd0);
    end
    tick();
    checkOutput("stall_out_ra", bus.out_ra, {16{8'h66}});
    checkOutput("stall_out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("stall_cnt_5", 128'(bus.stall_cnt), 128'd5);

    $display("[TB] youngest producer wins");
    clearTaps();
    bus.rf_rb_data = {16{8'hBB}};
    applyStimulus(1'b1, 3'b010, 7'd5, 7'd9, 7'd0);
    bus.tap[2] = mkTap(7'd9, 4'd2, 1'b1, {16{8'h22}});
    bus.tap[5] = mkTap(7'd9, 4'd2, 1'b1, {16{8'h55}});
    #1;
    checkOutput("young_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("young_out_rb", bus.out_rb, {16{8'h22}});

    $display("[TB] younger unready match beats older ready one");
    bus.tap[2] = '0;
    bus.tap[1] = mkTap(7'd9, 4'd5, 1'b1, {16{8'h99}});
    #1;
    checkOutput("young_unready_stall", 128'(bus.stall), 128'd1);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("invalid_no_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("invalid_out_valid", 128'(bus.out_valid), 128'd0);

    $display("[TB] write-back bypass and unused operand");
    clearTaps();
    applyStimulus(1'b1, 3'b100, 7'd5, 7'd0, 7'd7);
    bus.wb_en   = 1'b1;
    bus.wb_addr = 7'd7;
    bus.wb_data = {16{8'h77}};
    bus.tap[1]  = mkTap(7'd5, 4'd6, 1'b1, {16{8'h66}});
    #1;
    checkOutput("unused_no_stall", 128'(bus.stall), 128'd0);
    tick();
    checkOutput("wb_out_rc", bus.out_rc, {16{8'h77}});
    checkOutput("unused_out_ra", bus.out_ra, {16{8'hAA}});
    checkOutput("wb_out_valid", 128'(bus.out_valid), 128'd1);
    checkOutput("stall_cnt_hold", 128'(bus.stall_cnt), 128'd5);
    bus.wb_en = 1'b0;

    $display("[TB] reset asserted mid-stall");
    applyStimulus(1'b1, 3'b001, 7'd5, 7'd0, 7'd0);
    #1;
    checkOutput("rst_pre_stall", 128'(bus.stall), 128'd1);
    tick();
    checkOutput("rst_pre_cnt", 128'(bus.stall_cnt), 128'd6);
    rst = 1'b0;
    #1;
    checkOutput("rst_out_valid", 128'(bus.out_valid), 128'd0);
    checkOutput("rst_stall_cnt", 128'(bus.stall_cnt), 128'd0);
    checkOutput("rst_out_ra", bus.out_ra, 128'd0);
    checkOutput("rst_out_instr", 128'(bus.out_instr), 128'd0);
    clearTaps();
    #1;
    checkOutput("rst_stall_clear", 128'(bus.stall), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_out_ra", bus.out_ra, {16{8'hAA}});
    checkOutput("post_rst_out_valid", 128'(bus.out_valid), 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
